// File: rtl/tube_pkg.sv
// Shared definitions for the Tube ULA register blocks.
//   - Tube status flag bit positions (S, T, P, V, M, J, I, Q)
//   - 2-bit Gray encode/decode helpers used by the dual-clock FIFO pointers
//   - default data byte width
package tube_pkg;

  // Status/control flag bit positions within the Tube flag byte.
  localparam int FLAG_Q = 0;
  localparam int FLAG_I = 1;
  localparam int FLAG_J = 2;
  localparam int FLAG_M = 3;
  localparam int FLAG_V = 4;
  localparam int FLAG_P = 5;
  localparam int FLAG_T = 6;
  localparam int FLAG_S = 7;

  localparam int TUBE_DATA_W = 8;

  function automatic logic [1:0] gray2_from_bin(input logic [1:0] b);
    return {b[1], b[1] ^ b[0]};
  endfunction

  function automatic logic [1:0] gray2_to_bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/tube_ptr_sync.sv
// Multi-bit Gray pointer synchroniser.
// The input pointer changes by one bit per move, so sampling it through a
// plain flop chain always yields either the old or the new pointer value.
// Ports:
//   clk    in  destination-domain clock (rising edge)
//   rst_b  in  asynchronous active-low reset, clears every stage
//   d      in  Gray pointer from the source domain
//   q      out synchronised pointer (SYNC_STAGES clocks of latency)
module tube_ptr_sync #(
  parameter int SYNC_STAGES = 2,  // must be at least 2
  parameter int W           = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/tube_hp_r3_fifo.sv
// Tube register 3, host-to-parasite direction: 2-entry dual-clock byte FIFO.
// Host writes commit on the falling edge of h_phi2; parasite pops commit on
// the falling edge of p_phi2. Each side keeps its own Gray pointer and sees
// the other side's pointer through a synchroniser, so flags are pessimistic
// (host sees full longer, parasite sees empty longer) but never optimistic.
// Ports:
//   h_phi2, p_phi2          host / parasite bus clocks
//   h_rst_b                 async active-low reset for both domains
//   h_sel, h_rdnw, h_data   host register-3 access and write byte
//   one_byte_mode           1 = single-byte mode (V clear), 0 = two-byte mode
//   p_sel, p_rdnw           parasite register-3 access
//   p_data                  head-of-FIFO byte (stale byte when empty)
//   p_data_available        parasite: at least one byte held
//   p_two_bytes_available   parasite: two bytes held
//   h_full                  host: no room for a write in the current mode
//   h_overrun               sticky: a host write was dropped while full
module tube_hp_r3_fifo
  import tube_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = TUBE_DATA_W
) (
  input  logic              h_phi2,
  input  logic              p_phi2,
  input  logic              h_rst_b,
  input  logic              h_sel,
  input  logic              h_rdnw,
  input  logic [DATA_W-1:0] h_data,
  input  logic              one_byte_mode,
  input  logic              p_sel,
  input  logic              p_rdnw,
  output logic [DATA_W-1:0] p_data,
  output logic              p_data_available,
  output logic              p_two_bytes_available,
  output logic              h_full,
  output logic              h_overrun
);

  logic [DATA_W-1:0] mem [2];

  logic [1:0] wp;     // Gray, host domain
  logic [1:0] rp;     // Gray, parasite domain
  logic [1:0] wp_p;   // wp seen by parasite
  logic [1:0] rp_h;   // rp seen by host
  logic [1:0] wp_bin;
  logic [1:0] rp_bin;
  logic [1:0] h_cnt;
  logic [1:0] p_cnt;
  logic       wr_req;
  logic       wr_ok;
  logic       rd_ok;

  assign wp_bin = gray2_to_bin(wp);
  assign rp_bin = gray2_to_bin(rp);

  // Occupancy wraps modulo 4; legal values are 0..2.
  assign h_cnt = wp_bin - gray2_to_bin(rp_h);
  assign p_cnt = gray2_to_bin(wp_p) - rp_bin;

  // A mode switch to single-byte while two bytes are held keeps h_full high
  // until the parasite has drained both; nothing is discarded.
  assign h_full = one_byte_mode ? (h_cnt >= 2'd1) : (h_cnt == 2'd2);

  assign p_data_available      = (p_cnt != 2'd0);
  assign p_two_bytes_available = (p_cnt == 2'd2);

  assign wr_req = h_sel & ~h_rdnw;
  assign wr_ok  = wr_req & ~h_full;
  assign rd_ok  = p_sel & p_rdnw & p_data_available;

  // Host side: write pointer and sticky overrun.
  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      wp        <= 2'b00;
      h_overrun <= 1'b0;
    end else if (wr_req) begin
      if (h_full) h_overrun <= 1'b1;
      else        wp        <= gray2_from_bin(wp_bin + 2'd1);
    end
  end

  // Storage is deliberately not reset; its content is don't-care until written.
  always_ff @(negedge h_phi2) begin
    if (wr_ok) mem[wp_bin[0]] <= h_data;
  end

  // Parasite side: a pop when empty leaves rp untouched.
  always_ff @(negedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b)   rp <= 2'b00;
    else if (rd_ok) rp <= gray2_from_bin(rp_bin + 2'd1);
  end

  assign p_data = mem[rp_bin[0]];

  tube_ptr_sync #(.SYNC_STAGES(SYNC_STAGES), .W(2)) u_rp_to_h (
    .clk   (h_phi2),
    .rst_b (h_rst_b),
    .d     (rp),
    .q     (rp_h)
  );

  tube_ptr_sync #(.SYNC_STAGES(SYNC_STAGES), .W(2)) u_wp_to_p (
    .clk   (p_phi2),
    .rst_b (h_rst_b),
    .d     (wp),
    .q     (wp_p)
  );

endmodule
